// File: rtl/top_level_pkg.sv
// Package states: shared FSM state type and dithering constants for top_level.
//   state_t   - controller state encoding (also driven onto LED[3:0] and HEX5)
//   Threshold - gray level at or above which a pixel becomes white
//   Weight*   - error-diffusion weights in sixteenths (E, SW, S, SE)
package states;

  typedef enum logic [3:0] {
    S0_IDLE = 4'd0,
    S1_LOAD = 4'd1,
    S2_CC1  = 4'd2,
    S2_CC2  = 4'd3,
    S3_CC1  = 4'd4,
    S3_CC2  = 4'd5,
    S3_CC3  = 4'd6,
    S3_CC4  = 4'd7,
    S4_CC1  = 4'd8,
    S5_DONE = 4'd9
  } state_t;

  localparam logic [7:0] Threshold = 8'd128;

  localparam logic [3:0] WeightE  = 4'd7;
  localparam logic [3:0] WeightSw = 4'd3;
  localparam logic [3:0] WeightS  = 4'd5;
  localparam logic [3:0] WeightSe = 4'd1;

endpackage

// File: rtl/top_level_hex_to_sevenseg.sv
// hex_to_sevenseg: 4-bit value to active-low seven-segment pattern (bit order g..a).
//   hex - nibble to display
//   seg - segment drives, 0 = lit
// Only compiled when HEX_DISPLAY_EN is defined; the default build has no display logic.
`ifdef HEX_DISPLAY_EN
module hex_to_sevenseg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    unique case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule
`endif

// File: rtl/top_level.sv
// top_level: Floyd-Steinberg dithering accelerator for the MAX10 board.
// Loads an IMAGEX x IMAGEY 8-bit grayscale image from the MCU byte bus, dithers it in place
// to 0x00/0xFF with saturating error diffusion, then streams it back one pixel per cycle.
// Ports:
//   MAX10_CLK1_50     - system clock
//   KEY[1]            - asynchronous active-low reset; KEY[0], SW, SPI_CLK/MOSI/CS unused
//   MCU_TX_RDY        - MCU starts an image transfer (seen in S0_IDLE / S5_DONE only)
//   external_SPI_data - load byte
//   MCU_RX_RDY        - high while in S5_DONE
//   LED               - [3:0] state encoding, rest 0
//   HEX0..HEX5        - active-low 7-seg digits
//   SPI_MISO          - constant 0
//   data_valid        - sram_out_test holds a valid readback pixel
//   state, next_state - current / next controller state
//   sram_out_test     - registered readback pixel
// Optional macro HEX_DISPLAY_EN: HEX1:HEX0 show the current pixel address, HEX5 the state;
// without it every HEX output is blank (7'h7F).
module top_level
  import states::*;
#(
  parameter int CLOCK_SPEED      = 50000000,
  parameter int PIXEL_COUNTER    = 50000000 / CLOCK_SPEED,
  parameter int IMAGEX           = 4,
  parameter int IMAGEY           = 4,
  parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
  parameter int IMAGEXlog2       = $clog2(IMAGEX),
  parameter int IMAGEYlog2       = $clog2(IMAGEY),
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
  parameter int RGB_SIZE         = 8,
  parameter int ADJ_PIXELS       = 4
) (
  input  logic                MAX10_CLK1_50,
  input  logic [1:0]          KEY,
  input  logic [9:0]          SW,
  input  logic                SPI_CLK,
  input  logic                SPI_MOSI,
  input  logic                SPI_CS,
  input  logic                MCU_TX_RDY,
  input  logic [RGB_SIZE-1:0] external_SPI_data,
  output logic                MCU_RX_RDY,
  output logic [9:0]          LED,
  output logic [6:0]          HEX0,
  output logic [6:0]          HEX1,
  output logic [6:0]          HEX2,
  output logic [6:0]          HEX3,
  output logic [6:0]          HEX4,
  output logic [6:0]          HEX5,
  output logic                SPI_MISO,
  output logic                data_valid,
  output state_t              state,
  output state_t              next_state,
  output logic [RGB_SIZE-1:0] sram_out_test
);

  localparam logic [IMAGE_ADDR_WIDTH-1:0] LastAddr = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);
  localparam logic [IMAGE_ADDR_WIDTH-1:0] StepX    = IMAGE_ADDR_WIDTH'(IMAGEX);
  localparam logic [IMAGE_ADDR_WIDTH-1:0] AddrOne  = IMAGE_ADDR_WIDTH'(1);
  localparam logic [IMAGEXlog2-1:0]       LastCol  = IMAGEXlog2'(IMAGEX - 1);
  localparam logic [IMAGEXlog2-1:0]       ColOne   = IMAGEXlog2'(1);
  localparam logic [IMAGEYlog2-1:0]       LastRow  = IMAGEYlog2'(IMAGEY - 1);
  localparam logic [IMAGEYlog2-1:0]       RowOne   = IMAGEYlog2'(1);

  logic rst_n;
  assign rst_n = KEY[1];

  logic unused_inputs;
  assign unused_inputs = ^{KEY[0], SW, SPI_CLK, SPI_MOSI, SPI_CS, (ADJ_PIXELS == 4)};

  logic [RGB_SIZE-1:0] mem [IMAGE_SIZE];

  state_t                      state_q, state_d;
  logic [IMAGE_ADDR_WIDTH-1:0] addr_q;
  logic [IMAGEXlog2-1:0]       col_q;
  logic [IMAGEYlog2-1:0]       row_q;
  logic [31:0]                 pc_q;
  logic [RGB_SIZE-1:0]         old_q;
  logic [3:0]                  q_q;
  logic [RGB_SIZE-1:0]         sram_out_q;
  logic                        data_valid_q;

  logic load_tick, last_pixel;
  assign load_tick  = (state_q == S1_LOAD) && (pc_q == 32'(PIXEL_COUNTER - 1));
  assign last_pixel = (addr_q == LastAddr);

  // Quantisation of the pixel read in S2_CC1.
  logic                above;
  logic [RGB_SIZE-1:0] new_pix, err;
  always_comb begin
    above   = (old_q >= Threshold);
    new_pix = above ? '1 : '0;
    err     = above ? ~old_q : old_q;  // |old - new| without a subtractor
  end

  // Single write port: load byte, quantised pixel, or saturated neighbour update.
  logic                        mem_we, nb_en;
  logic [IMAGE_ADDR_WIDTH-1:0] mem_waddr, nb_addr;
  logic [RGB_SIZE-1:0]         mem_wdata, nb_rd, inc, nb_sat;
  logic [3:0]                  weight;
  logic [RGB_SIZE:0]           sum;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = new_pix;
    nb_addr   = addr_q + AddrOne;
    weight    = '0;
    nb_en     = 1'b0;
    unique case (state_q)
      S1_LOAD: begin
        mem_we    = load_tick;
        mem_wdata = external_SPI_data;
      end
      S2_CC2: mem_we = 1'b1;
      S3_CC1: begin
        nb_addr = addr_q + AddrOne;
        weight  = WeightE;
        nb_en   = (col_q != LastCol);
      end
      S3_CC2: begin
        nb_addr = addr_q + StepX - AddrOne;
        weight  = WeightSw;
        nb_en   = (row_q != LastRow) && (col_q != '0);
      end
      S3_CC3: begin
        nb_addr = addr_q + StepX;
        weight  = WeightS;
        nb_en   = (row_q != LastRow);
      end
      S3_CC4: begin
        nb_addr = addr_q + StepX + AddrOne;
        weight  = WeightSe;
        nb_en   = (row_q != LastRow) && (col_q != LastCol);
      end
      default: ;
    endcase
    nb_rd  = mem[nb_addr];
    inc    = RGB_SIZE'(weight) * RGB_SIZE'(q_q);
    sum    = {1'b0, nb_rd} + {1'b0, inc};
    nb_sat = sum[RGB_SIZE] ? '1 : sum[RGB_SIZE-1:0];
    if (nb_en) begin
      mem_we    = 1'b1;
      mem_waddr = nb_addr;
      mem_wdata = nb_sat;
    end
  end

  // Image storage is intentionally not reset.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // FSM: state register.
  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) state_q <= S0_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state. Held at idle while reset is asserted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S0_IDLE: if (MCU_TX_RDY) state_d = S1_LOAD;
      S1_LOAD: if (load_tick && last_pixel) state_d = S2_CC1;
      S2_CC1:  state_d = S2_CC2;
      S2_CC2:  state_d = S3_CC1;
      S3_CC1:  state_d = S3_CC2;
      S3_CC2:  state_d = S3_CC3;
      S3_CC3:  state_d = S3_CC4;
      S3_CC4:  state_d = last_pixel ? S4_CC1 : S2_CC1;
      S4_CC1:  if (last_pixel) state_d = S5_DONE;
      S5_DONE: if (MCU_TX_RDY) state_d = S1_LOAD;
      default: state_d = S0_IDLE;
    endcase
    if (!rst_n) state_d = S0_IDLE;
  end

  // Datapath counters and registers.
  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      pc_q         <= '0;
      old_q        <= '0;
      q_q          <= '0;
      sram_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      // Registered readback: valid lags the address by one cycle.
      data_valid_q <= (state_q == S4_CC1);
      unique case (state_q)
        S0_IDLE, S5_DONE: begin
          addr_q <= '0;
          col_q  <= '0;
          row_q  <= '0;
          pc_q   <= '0;
        end
        S1_LOAD: begin
          if (load_tick) begin
            pc_q   <= '0;
            addr_q <= last_pixel ? '0 : addr_q + AddrOne;
          end else begin
            pc_q <= pc_q + 32'd1;
          end
        end
        S2_CC1: old_q <= mem[addr_q];
        S2_CC2: q_q <= err[7:4];
        S3_CC4: begin
          if (last_pixel) begin
            addr_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
          end else begin
            addr_q <= addr_q + AddrOne;
            if (col_q == LastCol) begin
              col_q <= '0;
              row_q <= row_q + RowOne;
            end else begin
              col_q <= col_q + ColOne;
            end
          end
        end
        S4_CC1: begin
          sram_out_q <= mem[addr_q];
          addr_q     <= last_pixel ? '0 : addr_q + AddrOne;
        end
        default: ;
      endcase
    end
  end

  // FSM: outputs.
  always_comb begin
    MCU_RX_RDY = (state_q == S5_DONE);
    LED        = {6'b0, state_q};
  end

  assign SPI_MISO      = 1'b0;
  assign data_valid    = data_valid_q;
  assign sram_out_test = sram_out_q;
  assign state         = state_q;
  assign next_state    = state_d;

`ifdef HEX_DISPLAY_EN
  logic [7:0] hex_addr;
  assign hex_addr = 8'(addr_q);

  hex_to_sevenseg u_hex0 (.hex(hex_addr[3:0]), .seg(HEX0));
  hex_to_sevenseg u_hex1 (.hex(hex_addr[7:4]), .seg(HEX1));
  hex_to_sevenseg u_hex5 (.hex(state_q),       .seg(HEX5));
  assign HEX2 = 7'h7F;
  assign HEX3 = 7'h7F;
  assign HEX4 = 7'h7F;
`else
  assign HEX0 = 7'h7F;
  assign HEX1 = 7'h7F;
  assign HEX2 = 7'h7F;
  assign HEX3 = 7'h7F;
  assign HEX4 = 7'h7F;
  assign HEX5 = 7'h7F;
`endif

endmodule

// File: tb/tb_top_level.sv
// Scoreboard bench for top_level: expected readback bytes are queued when an image is
// issued; a negedge monitor pops and compares whenever data_valid is high.
module tb_top_level;
  import states::*;

  typedef logic [7:0] img_t [16];

  logic       clk = 1'b0;
  logic [1:0] key;
  logic [9:0] sw;
  logic       spi_clk, spi_mosi, spi_cs;
  logic       tx_rdy;
  logic [7:0] din;
  logic       rx_rdy;
  logic [9:0] led;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic       miso;
  logic       data_valid;
  state_t     state, next_state;
  logic [7:0] dout;

  always #10 clk = ~clk;

  top_level dut (
    .MAX10_CLK1_50    (clk),
    .KEY              (key),
    .SW               (sw),
    .SPI_CLK          (spi_clk),
    .SPI_MOSI         (spi_mosi),
    .SPI_CS           (spi_cs),
    .MCU_TX_RDY       (tx_rdy),
    .external_SPI_data(din),
    .MCU_RX_RDY       (rx_rdy),
    .LED              (led),
    .HEX0             (hex0),
    .HEX1             (hex1),
    .HEX2             (hex2),
    .HEX3             (hex3),
    .HEX4             (hex4),
    .HEX5             (hex5),
    .SPI_MISO         (miso),
    .data_valid       (data_valid),
    .state            (state),
    .next_state       (next_state),
    .sram_out_test    (dout)
  );

  int         vectors    = 0;
  int         miscompares = 0;
  int         beats      = 0;
  int         s2_entries = 0;
  logic [7:0] exp_q [$];
  img_t       img, expv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expected byte per valid readback beat.
  always @(negedge clk) begin
    if (key[1] && data_valid) begin
      beats++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL readback_extra: got 0x%0h, want no beat", dout);
      end else begin
        check("readback", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
    if (key[1] && state == S2_CC1) s2_entries++;
  end

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Reference Floyd-Steinberg on a 4x4 image with the same boundary skips.
  task automatic dither_model(input img_t src, output img_t res);
    int m [16];
    int old, nw, err, q, row, col;
    for (int p = 0; p < 16; p++) m[p] = int'(src[p]);
    for (int p = 0; p < 16; p++) begin
      row = p / 4;
      col = p % 4;
      old = m[p];
      nw  = (old >= 128) ? 255 : 0;
      err = (old >= 128) ? 255 - old : old;
      q   = err >> 4;
      m[p] = nw;
      if (col < 3)             m[p+1] = sat(m[p+1] + 7 * q);
      if (row < 3 && col > 0)  m[p+3] = sat(m[p+3] + 3 * q);
      if (row < 3)             m[p+4] = sat(m[p+4] + 5 * q);
      if (row < 3 && col < 3)  m[p+5] = sat(m[p+5] + q);
    end
    for (int p = 0; p < 16; p++) res[p] = 8'(m[p]);
  endtask

  task automatic load_image(input img_t src);
    @(negedge clk);
    beats      = 0;
    s2_entries = 0;
    tx_rdy     = 1'b1;
    @(negedge clk);
    tx_rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      din = src[i];
      @(negedge clk);
    end
  endtask

  task automatic run_image(input string tag, input img_t src, input img_t exp_img);
    int n;
    load_image(src);
    for (int k = 0; k < 16; k++) exp_q.push_back(exp_img[k]);
    n = 0;
    while (state != S5_DONE && n < 400) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_done", tag), 32'(state == S5_DONE), 32'd1);
    @(negedge clk);
    check($sformatf("%s_beats", tag), 32'(beats), 32'd16);
    check($sformatf("%s_s2_entries", tag), 32'(s2_entries), 32'd16);
    check($sformatf("%s_rx_rdy", tag), 32'(rx_rdy), 32'd1);
    check($sformatf("%s_led", tag), 32'(led), 32'd9);
    check($sformatf("%s_queue_drained", tag), 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    key      = 2'b01;
    sw       = '0;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    spi_cs   = 1'b0;
    tx_rdy   = 1'b0;
    din      = '0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 32'(S0_IDLE));
    check("rst_next_state", 32'(next_state), 32'(S0_IDLE));
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_sram_out", 32'(dout), 32'd0);
    check("rst_rx_rdy", 32'(rx_rdy), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_miso", 32'(miso), 32'd0);
`ifndef HEX_DISPLAY_EN
    check("rst_hex0", 32'(hex0), 32'h7F);
    check("rst_hex5", 32'(hex5), 32'h7F);
`endif
    key = 2'b11;
    repeat (2) @(negedge clk);
    check("idle_hold", 32'(state), 32'(S0_IDLE));

    // All 0x80: every pixel ends at 0xFF (hand-traced accumulation stays >= 128).
    for (int k = 0; k < 16; k++) begin img[k] = 8'h80; expv[k] = 8'hFF; end
    run_image("mid_gray", img, expv);

    // All 0x10: diffusion never lifts a pixel past the threshold.
    for (int k = 0; k < 16; k++) begin img[k] = 8'h10; expv[k] = 8'h00; end
    run_image("dark", img, expv);

    // 0xFF corner, 0xF0 elsewhere: q is 0 everywhere, all stay white.
    for (int k = 0; k < 16; k++) begin img[k] = 8'hF0; expv[k] = 8'hFF; end
    img[0] = 8'hFF;
    run_image("bright", img, expv);

    // 0x7F corner: q=7 pushes 0xF0 neighbours past 0xFF; a 9-bit wrap would turn pixel 1 black.
    for (int k = 0; k < 16; k++) begin img[k] = 8'hF0; expv[k] = 8'hFF; end
    img[0]  = 8'h7F;
    expv[0] = 8'h00;
    run_image("saturate", img, expv);

    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 16; k++) img[k] = 8'($urandom_range(0, 255));
      dither_model(img, expv);
      run_image($sformatf("random%0d", r), img, expv);
    end

    // Abort during S3_CC2, then a clean run.
    for (int k = 0; k < 16; k++) img[k] = 8'($urandom_range(0, 255));
    load_image(img);
    n = 0;
    while (state != S3_CC2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_s3_cc2", 32'(state == S3_CC2), 32'd1);
    #3 key = 2'b01;
    #1;
    check("abort_state", 32'(state), 32'(S0_IDLE));
    check("abort_next_state", 32'(next_state), 32'(S0_IDLE));
    check("abort_data_valid", 32'(data_valid), 32'd0);
    check("abort_sram_out", 32'(dout), 32'd0);
    check("abort_rx_rdy", 32'(rx_rdy), 32'd0);
    check("abort_no_beats", 32'(beats), 32'd0);
    @(negedge clk);
    key = 2'b11;
    for (int k = 0; k < 16; k++) img[k] = 8'($urandom_range(0, 255));
    dither_model(img, expv);
    run_image("after_abort", img, expv);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
